div_seq_restoring: RTL and testbench

// - Multi-cycle unsigned integer divider. It retires one quotient bit per cycle

---
 rtl/div_seq_restoring.sv | 124 ++++++++++++
 tb/tb_div_seq_restoring.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_seq_restoring.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle through a
// single WIDTH+1-bit shift/subtract step, with a go/busy/done handshake.
module div_seq_restoring #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   step_reg;
  logic [WIDTH-1:0]   partial_reg;
  logic [WIDTH-1:0]   shift_reg;
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               dbz_reg;

  logic               accept;
  logic               last_step;
  logic               divisor_zero;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   partial_new;
  logic [WIDTH-1:0]   quot_new;

  assign accept       = go && (state_reg != COMPUTE);
  assign last_step    = (step_reg == CNT_W'(WIDTH - 1));
  assign divisor_zero = (divisor == '0);

  // shift_reg starts as the dividend; its MSB feeds the partial remainder while
  // quotient bits fill in from the LSB, so it holds the quotient after WIDTH steps.
  assign shifted     = {partial_reg, shift_reg[WIDTH-1]};
  assign trial       = shifted - {1'b0, divisor_reg};
  assign q_bit       = ~trial[WIDTH];
  assign partial_new = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_new    = {shift_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (go) begin
          state_next = divisor_zero ? DONE : COMPUTE;
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (go) begin
          state_next = divisor_zero ? DONE : COMPUTE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers change only at completion or on a divide-by-zero accept,
  // so a result stays stable for as long as done is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_reg      <= '0;
      partial_reg   <= '0;
      shift_reg     <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else if (accept) begin
      step_reg    <= '0;
      partial_reg <= '0;
      shift_reg   <= dividend;
      divisor_reg <= divisor;
      if (divisor_zero) begin
        quotient_reg  <= '1;
        remainder_reg <= dividend;
        dbz_reg       <= 1'b1;
      end else begin
        dbz_reg <= 1'b0;
      end
    end else if (state_reg == COMPUTE) begin
      step_reg    <= step_reg + 1'b1;
      partial_reg <= partial_new;
      shift_reg   <= quot_new;
      if (last_step) begin
        quotient_reg  <= quot_new;
        remainder_reg <= partial_new;
      end
    end
  end

  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_div_seq_restoring.sv
// Self-checking bench for div_seq_restoring: directed cases plus random operands
// on an 8-bit and a 32-bit instance, checked against plain / and % arithmetic.
module tb_div_seq_restoring;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        go8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, q8, r8;
  logic        dbz8, busy8, done8;

  logic        go32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, q32, r32;
  logic        dbz32, busy32, done32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq_restoring #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .go(go8), .dividend(a8), .divisor(b8),
    .quotient(q8), .remainder(r8), .div_by_zero(dbz8), .busy(busy8), .done(done8)
  );

  div_seq_restoring #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .go(go32), .dividend(a32), .divisor(b32),
    .quotient(q32), .remainder(r32), .div_by_zero(dbz32), .busy(busy32), .done(done32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full division on the 8-bit instance; entered at a negedge from IDLE or DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input string tag);
    int lat, busy_cnt;
    logic [7:0] eq, er;
    eq = (b == 0) ? 8'hFF : 8'(a / b);
    er = (b == 0) ? a : 8'(a % b);
    @(negedge clk);
    go8 = 1'b1; a8 = a; b8 = b;
    @(negedge clk);
    go8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'd9);
    check({tag, " busy_cycles"}, 64'(busy_cnt), (b == 0) ? 64'd0 : 64'd8);
    check({tag, " quotient"}, 64'(q8), 64'(eq));
    check({tag, " remainder"}, 64'(r8), 64'(er));
    check({tag, " dbz"}, 64'(dbz8), 64'(b == 0));
    $display("txn w8 %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, q8, r8, dbz8, lat);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input string tag);
    int lat, busy_cnt;
    logic [31:0] eq, er;
    eq = (b == 0) ? 32'hFFFF_FFFF : a / b;
    er = (b == 0) ? a : a % b;
    @(negedge clk);
    go32 = 1'b1; a32 = a; b32 = b;
    @(negedge clk);
    go32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 1; busy_cnt = 0;
    while (!done32 && lat < 80) begin
      if (busy32) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), (b == 0) ? 64'd1 : 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), (b == 0) ? 64'd0 : 64'd32);
    check({tag, " quotient"}, 64'(q32), 64'(eq));
    check({tag, " remainder"}, 64'(r32), 64'(er));
    check({tag, " dbz"}, 64'(dbz32), 64'(b == 0));
    $display("txn w32 %s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, q32, r32, dbz32, lat);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset q8", 64'(q8), 64'd0);
    check("reset r8", 64'(r8), 64'd0);
    check("reset dbz8", 64'(dbz8), 64'd0);
    check("reset busy32/done32", 64'({busy32, done32}), 64'd0);
    rst_n = 1'b1;

    run8(8'd100, 8'd7, "100/7");
    run8(8'd255, 8'd1, "255/1");
    run8(8'd5, 8'd9, "5/9");
    run8(8'd0, 8'd3, "0/3");
    run8(8'd77, 8'd0, "77/0");
    run8(8'd12, 8'd0, "12/0 back-to-back");
    run8(8'd255, 8'd255, "255/255");
    run8(8'd254, 8'd255, "254/255");
    run8(8'd128, 8'd128, "128/128");

    // go held high with operands churning during busy; the result must not move.
    @(negedge clk);
    go8 = 1'b1; a8 = 8'd200; b8 = 8'd3;
    @(negedge clk);
    n = 1;
    while (!done8 && n < 40) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(negedge clk);
      n++;
    end
    check("hold latency", 64'(n), 64'd9);
    check("hold quotient", 64'(q8), 64'd66);
    check("hold remainder", 64'(r8), 64'd2);
    check("hold dbz", 64'(dbz8), 64'd0);
    $display("txn w8 hold-go: 200 / 3 -> q=%0d r=%0d", q8, r8);
    a8 = 8'd50; b8 = 8'd5;
    @(negedge clk);
    go8 = 1'b0;
    check("restart done drops", 64'(done8), 64'd0);
    check("restart busy", 64'(busy8), 64'd1);
    n = 1;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("restart latency", 64'(n), 64'd9);
    check("restart quotient", 64'(q8), 64'd10);
    check("restart remainder", 64'(r8), 64'd0);
    $display("txn w8 restart: 50 / 5 -> q=%0d r=%0d", q8, r8);

    // Reset asserted in cycle 4 of a computation.
    @(negedge clk);
    go8 = 1'b1; a8 = 8'd100; b8 = 8'd7;
    @(negedge clk);
    go8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-reset busy", 64'(busy8), 64'd0);
    check("mid-reset done", 64'(done8), 64'd0);
    check("mid-reset quotient", 64'(q8), 64'd0);
    check("mid-reset remainder", 64'(r8), 64'd0);
    check("mid-reset dbz", 64'(dbz8), 64'd0);
    $display("txn w8 reset mid-compute: outputs cleared");
    rst_n = 1'b1;
    run8(8'd100, 8'd7, "post-reset 100/7");

    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 16 == 0) rb = 32'd0;
      else if (i % 4 == 0) rb = 32'($urandom_range(1, 15));
      run8(ra[7:0], rb[7:0], "rand8");
    end

    run32(32'hFFFF_FFFF, 32'd1, "max/1");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max/max");
    run32(32'd12345, 32'd0, "x/0");
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 20 == 0) rb = 32'd0;
      else if (i % 3 == 0) rb = rb >> $urandom_range(8, 31);
      run32(ra, rb, "rand32");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
